// File: rtl/sprite_scan_arbiter_pkg.sv
// Shared definitions for the sprite scan arbiter: sprite word layout, defaults
// and the lookup FSM state encoding.
package sprite_scan_arbiter_pkg;

    localparam int EN_BIT  = 31;
    localparam int X_MSB   = 26;
    localparam int X_LSB   = 18;
    localparam int Y_MSB   = 17;
    localparam int Y_LSB   = 9;
    localparam int OFF_MSB = 8;
    localparam int OFF_LSB = 0;

    localparam logic [31:0] BG_CODE     = 32'h0000_0001;
    localparam int          SPRITE_SIZE = 20;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/sprite_hit_check.sv
// Combinational test of whether one sprite word covers a pixel coordinate.
// Shared between the lookup scan and the collision logic.
module sprite_hit_check #(
    parameter int SPRITE_SIZE = sprite_scan_arbiter_pkg::SPRITE_SIZE
) (
    input  logic [31:0] sprite_i,
    input  logic [17:0] coord_i,
    output logic        hit_o
);
    import sprite_scan_arbiter_pkg::*;

    logic [9:0] xLo;
    logic [9:0] yLo;
    logic [9:0] xHi;
    logic [9:0] yHi;
    logic [9:0] px;
    logic [9:0] py;
    logic       unusedBits;

    // Bounds are widened to 10 bits so an origin near 511 cannot wrap to 0.
    assign xLo = {1'b0, sprite_i[X_MSB:X_LSB]};
    assign yLo = {1'b0, sprite_i[Y_MSB:Y_LSB]};
    assign xHi = xLo + 10'(SPRITE_SIZE);
    assign yHi = yLo + 10'(SPRITE_SIZE);
    assign px  = {1'b0, coord_i[17:9]};
    assign py  = {1'b0, coord_i[8:0]};

    assign hit_o = sprite_i[EN_BIT]
                 && (px >= xLo) && (px < xHi)
                 && (py >= yLo) && (py < yHi);

    assign unusedBits = ^{sprite_i[30:27], sprite_i[OFF_MSB:OFF_LSB]};

endmodule

// File: rtl/sprite_scan_arbiter.sv
// Sprite register bank with a priority-ordered lookup scan; CPU writes are
// only serviced while the scan FSM is idle.
module sprite_scan_arbiter #(
    parameter int          NUM_SPRITES = 32,
    parameter int          SPRITE_SIZE = sprite_scan_arbiter_pkg::SPRITE_SIZE,
    parameter logic [31:0] BG_CODE     = sprite_scan_arbiter_pkg::BG_CODE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    output logic        wr_ack,
    input  logic        lookup_req,
    input  logic [17:0] check_value,
    output logic        lookup_ready,
    output logic [31:0] data_reg,
    output logic        data_valid
);
    import sprite_scan_arbiter_pkg::*;

    localparam logic [4:0] LAST_IDX = 5'(NUM_SPRITES - 1);

    logic [31:0] bank_q [NUM_SPRITES];
    state_e      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [17:0] coord_q, coord_d;
    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        bankWrEn;
    logic [31:0] scanWord;
    logic        scanHit;

    assign lookup_ready = (state_q == IDLE);
    assign wr_ack       = wr_en && (state_q == IDLE);
    assign bankWrEn     = wr_ack && ({1'b0, wr_addr} < 6'(NUM_SPRITES));
    assign scanWord     = bank_q[idx_q];
    assign data_reg     = data_q;
    assign data_valid   = valid_q;

    // Out-of-range writes are still acked so the CPU never stalls on them.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                bank_q[i] <= '0;
            end
        end else if (bankWrEn) begin
            bank_q[wr_addr] <= wr_data;
        end
    end

    sprite_hit_check #(
        .SPRITE_SIZE(SPRITE_SIZE)
    ) u_hit (
        .sprite_i(scanWord),
        .coord_i (coord_q),
        .hit_o   (scanHit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            coord_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            coord_q <= coord_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    // One sprite per SCAN cycle, lowest index first, so the first hit wins.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        coord_d = coord_q;
        data_d  = data_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (lookup_req) begin
                    coord_d = check_value;
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (scanHit) begin
                    data_d  = scanWord;
                    valid_d = 1'b1;
                    state_d = DONE;
                end else if (idx_q == LAST_IDX) begin
                    data_d  = BG_CODE;
                    valid_d = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sprite_scan_arbiter.sv
// Scoreboard-driven bench for sprite_scan_arbiter: expected (word, latency)
// pairs are queued when a lookup is issued and popped when data_valid fires.
module tb_sprite_scan_arbiter;

    localparam logic [31:0] BG = 32'h0000_0001;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_ack;
    logic        lookup_req;
    logic [17:0] check_value;
    logic        lookup_ready;
    logic [31:0] data_reg;
    logic        data_valid;

    typedef struct {
        logic [31:0] data;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   testsRun    = 0;
    int   testsFailed = 0;

    always #5 clk = ~clk;

    sprite_scan_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ack      (wr_ack),
        .lookup_req  (lookup_req),
        .check_value (check_value),
        .lookup_ready(lookup_ready),
        .data_reg    (data_reg),
        .data_valid  (data_valid)
    );

    function automatic logic [31:0] mkSprite(input logic en, input int x, input int y, input int off);
        return {en, 4'b0000, 9'(x), 9'(y), 9'(off)};
    endfunction

    task automatic cpu_write(input logic [4:0] a, input logic [31:0] d);
        bit done = 0;
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        for (int k = 0; k < 60 && !done; k++) begin
            #1;
            if (wr_ack) done = 1;
            else @(negedge clk);
        end
        testsRun++;
        if (!done) begin
            testsFailed++;
            $display("[TB] FAIL write_ack_timeout addr=%0d: wr_ack never seen, required 1", a);
        end
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Returns right after the accept edge when the request was taken.
    task automatic start_lookup(input int px, input int py, output bit acc);
        acc = 0;
        @(negedge clk);
        lookup_req  = 1'b1;
        check_value = {9'(px), 9'(py)};
        for (int k = 0; k < 60 && !acc; k++) begin
            #1;
            if (lookup_ready) acc = 1;
            else @(negedge clk);
        end
        if (acc) @(posedge clk);
    endtask

    task automatic wait_result(output logic [31:0] d, output int lat, output bit ok);
        ok  = 0;
        lat = 0;
        d   = 'x;
        for (int k = 0; k < 80 && !ok; k++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            lookup_req = 1'b0;
            if (data_valid) begin
                ok = 1;
                d  = data_reg;
            end
        end
    endtask

    task automatic run_lookup(input int px, input int py, output logic [31:0] d, output int lat, output bit ok);
        bit acc;
        start_lookup(px, py, acc);
        if (acc) begin
            wait_result(d, lat, ok);
        end else begin
            lookup_req = 1'b0;
            d   = 'x;
            lat = -1;
            ok  = 0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        lookup_req = 1'b0; check_value = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        testsRun++;
        if (lookup_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL reset_ready got=%b want=1", lookup_ready);
        end
        testsRun++;
        if (data_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_valid got=%b want=0", data_valid);
        end
        testsRun++;
        if (data_reg !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_data got=%h want=00000000", data_reg);
        end
        testsRun++;
        if (wr_ack !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_wr_ack got=%b want=0", wr_ack);
        end
    endtask

    task automatic test_lookup(input string name, input int px, input int py, input logic [31:0] expData, input int expLat);
        logic [31:0] d;
        int          lat;
        bit          ok;
        exp_t        e;
        sb.push_back('{data: expData, lat: expLat});
        run_lookup(px, py, d, lat, ok);
        e = sb.pop_front();
        testsRun++;
        if (!ok) begin
            testsFailed++;
            $display("[TB] FAIL %s_timeout: no data_valid, required at cycle %0d", name, e.lat);
        end else begin
            if (d !== e.data) begin
                testsFailed++;
                $display("[TB] FAIL %s_data got=%h want=%h", name, d, e.data);
            end
            testsRun++;
            if (lat !== e.lat) begin
                testsFailed++;
                $display("[TB] FAIL %s_latency got=%0d want=%0d", name, lat, e.lat);
            end
        end
    endtask

    task automatic test_bg_miss();
        test_lookup("bg_after_reset", 100, 50, BG, 32);
    endtask

    task automatic test_hit_edge();
        cpu_write(5'd3, mkSprite(1'b1, 100, 40, 7));
        test_lookup("hit_edge_in", 119, 59, mkSprite(1'b1, 100, 40, 7), 4);
        test_lookup("hit_edge_out", 120, 59, BG, 32);
        test_lookup("hit_origin", 100, 40, mkSprite(1'b1, 100, 40, 7), 4);
    endtask

    task automatic test_priority();
        cpu_write(5'd5, mkSprite(1'b1, 0, 0, 5));
        cpu_write(5'd1, mkSprite(1'b1, 5, 5, 1));
        test_lookup("priority", 10, 10, mkSprite(1'b1, 5, 5, 1), 2);
    endtask

    task automatic test_no_wrap();
        cpu_write(5'd7, mkSprite(1'b1, 500, 300, 9));
        test_lookup("no_wrap", 511, 310, mkSprite(1'b1, 500, 300, 9), 8);
        cpu_write(5'd7, mkSprite(1'b0, 500, 300, 9));
        test_lookup("disabled", 511, 310, BG, 32);
    endtask

    task automatic test_write_stall();
        logic [31:0] d = 'x;
        int          lat = -1;
        bit          acc;
        exp_t        e;
        sb.push_back('{data: mkSprite(1'b1, 100, 40, 7), lat: 4});
        start_lookup(119, 59, acc);
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            lookup_req = 1'b0;
            if (k == 0) begin
                wr_en   = 1'b1;
                wr_addr = 5'd10;
                wr_data = mkSprite(1'b1, 200, 200, 10);
            end
            #1;
            testsRun++;
            if (wr_ack !== (k == 5)) begin
                testsFailed++;
                $display("[TB] FAIL stall_wr_ack cycle=%0d got=%b want=%b", k, wr_ack, (k == 5));
            end
            if (data_valid && lat < 0) begin
                d   = data_reg;
                lat = k;
            end
            if (k < 5) @(posedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        e = sb.pop_front();
        testsRun++;
        if (d !== e.data || lat !== e.lat) begin
            testsFailed++;
            $display("[TB] FAIL stall_result got=%h@%0d want=%h@%0d", d, lat, e.data, e.lat);
        end
        test_lookup("stalled_write_landed", 205, 205, mkSprite(1'b1, 200, 200, 10), 11);
    endtask

    task automatic test_back_to_back();
        logic [31:0] w0;
        logic [31:0] d;
        int          lat;
        bit          ok;
        exp_t        e;
        w0 = mkSprite(1'b1, 300, 400, 3) | 32'h7800_0000;
        sb.push_back('{data: w0, lat: 1});
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = w0;
        lookup_req = 1'b1; check_value = {9'd305, 9'd405};
        #1;
        testsRun++;
        if (wr_ack !== 1'b1 || lookup_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL simul_accept got ack=%b ready=%b want ack=1 ready=1", wr_ack, lookup_ready);
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        wait_result(d, lat, ok);
        e = sb.pop_front();
        testsRun++;
        if (!ok || d !== e.data || lat !== e.lat) begin
            testsFailed++;
            $display("[TB] FAIL simul_write_lookup got=%h@%0d want=%h@%0d", d, lat, e.data, e.lat);
        end
        test_lookup("back_to_back", 10, 10, mkSprite(1'b1, 5, 5, 1), 2);
    endtask

    task automatic test_reset_mid_scan();
        bit acc;
        bit sawValid = 0;
        start_lookup(50, 300, acc);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            lookup_req = 1'b0;
            if (data_valid) sawValid = 1;
            @(posedge clk);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        testsRun++;
        if (lookup_ready !== 1'b1 || data_valid !== 1'b0 || data_reg !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL mid_reset_state got ready=%b valid=%b data=%h want 1 0 00000000",
                     lookup_ready, data_valid, data_reg);
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (data_valid) sawValid = 1;
        end
        testsRun++;
        if (sawValid) begin
            testsFailed++;
            $display("[TB] FAIL mid_reset_no_valid got valid=1 want none");
        end
        test_lookup("cleared_reg1", 10, 10, BG, 32);
        test_lookup("cleared_reg3", 119, 59, BG, 32);
        test_lookup("cleared_reg0", 305, 405, BG, 32);
    endtask

    initial begin
        test_reset();
        test_bg_miss();
        test_hit_edge();
        test_priority();
        test_no_wrap();
        test_write_stall();
        test_back_to_back();
        test_reset_mid_scan();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
